// File: rtl/line_follow_ctrl.sv
// Line-follower motion controller: synchronises and debounces the reflective
// sensor array, runs the tracking FSM and produces driver commands and lap count.
module line_follow_ctrl #(
  parameter int          N_SENZ   = 5,
  parameter int          DC_W     = 12,
  parameter int unsigned DC_MAX   = 32'h999,
  parameter int unsigned DC_STEP  = 32'h200,
  parameter int unsigned DC_TURN  = 32'h600,
  parameter int          DEB_CYC  = 16,
  parameter int          LOST_CYC = 50000,
  parameter int          LAP_W    = 8,
  parameter int          LIM_C1   = 2,
  parameter int          LIM_C2   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_SENZ-1:0] senzori,
  input  logic [1:0]        circuit,
  output logic [1:0]        directie_driverA,
  output logic [1:0]        directie_driverB,
  output logic [DC_W-1:0]   factor_dc_driverA,
  output logic [DC_W-1:0]   factor_dc_driverB,
  output logic              semnal_dreapta,
  output logic              semnal_stanga,
  output logic              stop,
  output logic              tact_count,
  output logic [LAP_W-1:0]  count_ture,
  output logic [2:0]        stare
);

  localparam int C     = N_SENZ / 2;
  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam int TMR_W = $clog2(LOST_CYC + 1);

  localparam logic [1:0] SIDE_NONE  = 2'd0;
  localparam logic [1:0] SIDE_RIGHT = 2'd1;
  localparam logic [1:0] SIDE_LEFT  = 2'd2;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_BRAKE = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FOLLOW   = 3'd1,
    S_SEARCH_R = 3'd2,
    S_SEARCH_L = 3'd3,
    S_LOST     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // input path
  logic [N_SENZ-1:0] sync1_q, sync1_d;
  logic [N_SENZ-1:0] sync2_q, sync2_d;
  logic [N_SENZ-1:0] hold_q, hold_d;
  logic [N_SENZ-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // tracking state
  state_t            state_q, state_d;
  logic [1:0]        side_q, side_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              fin_prev_q, fin_prev_d;
  logic [LAP_W-1:0]  count_q, count_d;
  logic              tact_q, tact_d;

  // registered outputs
  logic [1:0]        dir_a_q, dir_a_d;
  logic [1:0]        dir_b_q, dir_b_d;
  logic [DC_W-1:0]   dc_a_q, dc_a_d;
  logic [DC_W-1:0]   dc_b_q, dc_b_d;
  logic              sd_q, sd_d;
  logic              ss_q, ss_d;
  logic              stop_q, stop_d;

  // derived from the debounced vector
  logic              r_any, l_any, fin;
  int unsigned       off_r, off_l;
  logic              lap_hit, run_st;

  function automatic logic [DC_W-1:0] trim_duty(input int unsigned off);
    int unsigned cut;
    cut = off * DC_STEP;
    if (cut >= DC_MAX) trim_duty = '0;
    else               trim_duty = DC_W'(DC_MAX - cut);
  endfunction

  // A vector is accepted once the synchronised input has matched itself
  // for DEB_CYC consecutive samples.
  always_comb begin
    sync1_d = senzori;
    sync2_d = sync1_q;
    hold_d  = sync2_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    if (sync2_q != hold_q) begin
      cnt_d = CNT_W'(1);
    end else begin
      if (cnt_q < CNT_W'(DEB_CYC)) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DEB_CYC - 1)) deb_d = sync2_q;
    end
  end

  always_comb begin
    r_any = 1'b0;
    l_any = 1'b0;
    off_r = 0;
    off_l = 0;
    for (int i = C - 1; i >= 1; i--) begin
      if (deb_q[i]) begin
        r_any = 1'b1;
        off_r = C - i;
      end
    end
    for (int i = C + 1; i <= N_SENZ - 2; i++) begin
      if (deb_q[i]) begin
        l_any = 1'b1;
        off_l = i - C;
      end
    end
    fin = deb_q[0] & deb_q[1] & deb_q[N_SENZ-2] & deb_q[N_SENZ-1];
  end

  always_comb begin
    state_d    = state_q;
    side_d     = side_q;
    tmr_d      = tmr_q;
    count_d    = count_q;
    tact_d     = 1'b0;
    fin_prev_d = fin;
    lap_hit    = ((circuit == 2'b01) && (count_q >= LAP_W'(LIM_C1))) ||
                 ((circuit == 2'b10) && (count_q >= LAP_W'(LIM_C2)));
    run_st     = (state_q == S_FOLLOW) || (state_q == S_SEARCH_R) ||
                 (state_q == S_SEARCH_L);

    // A held mark produces one edge, so it is counted exactly once.
    if (circuit == 2'b00) begin
      count_d = '0;
    end else if (run_st && fin && !fin_prev_q) begin
      tact_d = 1'b1;
      if (count_q != '1) count_d = count_q + LAP_W'(1);
    end

    if (!enable || circuit == 2'b00) begin
      state_d = S_IDLE;
    end else if (lap_hit) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FOLLOW;
        S_FOLLOW: begin
          if (r_any ^ l_any) begin
            side_d = r_any ? SIDE_RIGHT : SIDE_LEFT;
          end else if (!r_any && !l_any && !deb_q[C]) begin
            tmr_d = '0;
            case (side_q)
              SIDE_RIGHT: state_d = S_SEARCH_R;
              SIDE_LEFT:  state_d = S_SEARCH_L;
              default:    state_d = S_LOST;
            endcase
          end
        end
        S_SEARCH_R, S_SEARCH_L: begin
          if (deb_q[C] | r_any | l_any)           state_d = S_FOLLOW;
          else if (tmr_q == TMR_W'(LOST_CYC - 1)) state_d = S_LOST;
          else                                    tmr_d = tmr_q + TMR_W'(1);
        end
        S_LOST:  if (deb_q[C]) state_d = S_FOLLOW;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs follow the state being entered so they land with stare.
  always_comb begin
    dir_a_d = DIR_BRAKE;
    dir_b_d = DIR_BRAKE;
    dc_a_d  = '0;
    dc_b_d  = '0;
    stop_d  = 1'b1;
    sd_d    = deb_q[0];
    ss_d    = deb_q[N_SENZ-1];
    case (state_d)
      S_FOLLOW: begin
        dir_a_d = DIR_FWD;
        dir_b_d = DIR_FWD;
        dc_a_d  = DC_W'(DC_MAX);
        dc_b_d  = DC_W'(DC_MAX);
        stop_d  = ~deb_q[C];
        if (r_any && !l_any) dc_b_d = trim_duty(off_r);
        if (l_any && !r_any) dc_a_d = trim_duty(off_l);
      end
      S_SEARCH_R: begin
        dir_a_d = DIR_REV;
        dir_b_d = DIR_FWD;
        dc_a_d  = DC_W'(DC_TURN);
        dc_b_d  = DC_W'(DC_TURN);
      end
      S_SEARCH_L: begin
        dir_a_d = DIR_FWD;
        dir_b_d = DIR_REV;
        dc_a_d  = DC_W'(DC_TURN);
        dc_b_d  = DC_W'(DC_TURN);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      hold_q     <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      side_q     <= SIDE_NONE;
      tmr_q      <= '0;
      fin_prev_q <= 1'b0;
      count_q    <= '0;
      tact_q     <= 1'b0;
      dir_a_q    <= DIR_BRAKE;
      dir_b_q    <= DIR_BRAKE;
      dc_a_q     <= '0;
      dc_b_q     <= '0;
      sd_q       <= 1'b0;
      ss_q       <= 1'b0;
      stop_q     <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hold_q     <= hold_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      side_q     <= side_d;
      tmr_q      <= tmr_d;
      fin_prev_q <= fin_prev_d;
      count_q    <= count_d;
      tact_q     <= tact_d;
      dir_a_q    <= dir_a_d;
      dir_b_q    <= dir_b_d;
      dc_a_q     <= dc_a_d;
      dc_b_q     <= dc_b_d;
      sd_q       <= sd_d;
      ss_q       <= ss_d;
      stop_q     <= stop_d;
    end
  end

  assign directie_driverA  = dir_a_q;
  assign directie_driverB  = dir_b_q;
  assign factor_dc_driverA = dc_a_q;
  assign factor_dc_driverB = dc_b_q;
  assign semnal_dreapta    = sd_q;
  assign semnal_stanga     = ss_q;
  assign stop              = stop_q;
  assign tact_count        = tact_q;
  assign count_ture        = count_q;
  assign stare             = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: directed and random sensor stimulus, every cycle
// checked against a behavioural model through an expected-response queue.
module tb_line_follow_ctrl;

  localparam int N     = 5;
  localparam int C     = N / 2;
  localparam int DEB   = 4;
  localparam int LOSTC = 20;
  localparam int MAXV  = 'h999;
  localparam int STEPV = 'h200;
  localparam int TURNV = 'h600;

  localparam int ST_IDLE = 0, ST_FOLLOW = 1, ST_SR = 2, ST_SL = 3, ST_LOST = 4, ST_DONE = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [N-1:0] senzori;
  logic [1:0]   circuit;
  logic [1:0]   directie_driverA, directie_driverB;
  logic [11:0]  factor_dc_driverA, factor_dc_driverB;
  logic         semnal_dreapta, semnal_stanga, stop, tact_count;
  logic [7:0]   count_ture;
  logic [2:0]   stare;

  line_follow_ctrl #(.N_SENZ(N), .DEB_CYC(DEB), .LOST_CYC(LOSTC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .senzori(senzori), .circuit(circuit),
    .directie_driverA(directie_driverA), .directie_driverB(directie_driverB),
    .factor_dc_driverA(factor_dc_driverA), .factor_dc_driverB(factor_dc_driverB),
    .semnal_dreapta(semnal_dreapta), .semnal_stanga(semnal_stanga), .stop(stop),
    .tact_count(tact_count), .count_ture(count_ture), .stare(stare)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  dir_a, dir_b;
    logic [11:0] dc_a, dc_b;
    logic        sd, ss, stop, tact;
    logic [7:0]  count;
    logic [2:0]  stare;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tact_seen = 0;

  // behavioural model state
  logic [N-1:0] m_s1;
  logic [N-1:0] m_s2_hist[$];
  logic [N-1:0] m_d, m_d_prev;
  int m_state, m_side, m_search, m_count;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  function automatic int duty(input int off);
    if (off * STEPV >= MAXV) return 0;
    return MAXV - off * STEPV;
  endfunction

  // Predicts the outputs after the coming rising edge and pushes them.
  task automatic model_step();
    exp_t e;
    logic [N-1:0] d_new;
    bit stable, r, l, fin_now, fin_before, lap_hit, running;
    int nst, off_r, off_l;
    e = '0;
    if (!rst_n) begin
      m_s1 = '0;
      m_s2_hist = {};
      for (int i = 0; i < DEB; i++) m_s2_hist.push_back('0);
      m_d = '0; m_d_prev = '0;
      m_state = ST_IDLE; m_side = 0; m_search = 0; m_count = 0;
      e.stop = 1'b1;
      exp_q.push_back(e);
      return;
    end
    stable = 1;
    foreach (m_s2_hist[i]) if (m_s2_hist[i] != m_s2_hist[DEB-1]) stable = 0;
    d_new = stable ? m_s2_hist[DEB-1] : m_d;

    r = 0; l = 0; off_r = 0; off_l = 0;
    for (int i = 1; i < C; i++) if (m_d[i]) begin r = 1; if (C - i > off_r) off_r = C - i; end
    for (int i = C + 1; i <= N - 2; i++) if (m_d[i]) begin l = 1; if (i - C > off_l) off_l = i - C; end
    fin_now    = m_d[0] && m_d[1] && m_d[N-2] && m_d[N-1];
    fin_before = m_d_prev[0] && m_d_prev[1] && m_d_prev[N-2] && m_d_prev[N-1];
    lap_hit    = (circuit == 2'b01 && m_count >= 2) || (circuit == 2'b10 && m_count >= 11);
    running    = (m_state == ST_FOLLOW || m_state == ST_SR || m_state == ST_SL);

    nst = m_state;
    if (!enable || circuit == 2'b00) nst = ST_IDLE;
    else if (lap_hit) nst = ST_DONE;
    else if (m_state == ST_IDLE) nst = ST_FOLLOW;
    else if (m_state == ST_FOLLOW) begin
      if (r != l) m_side = r ? 1 : 2;
      else if (!r && !l && !m_d[C]) begin
        m_search = 0;
        nst = (m_side == 1) ? ST_SR : (m_side == 2) ? ST_SL : ST_LOST;
      end
    end else if (m_state == ST_SR || m_state == ST_SL) begin
      if (m_d[C] || r || l) nst = ST_FOLLOW;
      else if (m_search + 1 >= LOSTC) nst = ST_LOST;
      else m_search++;
    end else if (m_state == ST_LOST) begin
      if (m_d[C]) nst = ST_FOLLOW;
    end

    if (circuit == 2'b00) m_count = 0;
    else if (running && fin_now && !fin_before) begin
      e.tact = 1'b1;
      if (m_count < 255) m_count++;
    end

    e.stop = 1'b1;
    if (nst == ST_FOLLOW) begin
      e.dir_a = 2'b10; e.dir_b = 2'b10;
      e.dc_a = 12'(MAXV); e.dc_b = 12'(MAXV);
      e.stop = !m_d[C];
      if (r && !l) e.dc_b = 12'(duty(off_r));
      if (l && !r) e.dc_a = 12'(duty(off_l));
    end else if (nst == ST_SR) begin
      e.dir_a = 2'b01; e.dir_b = 2'b10; e.dc_a = 12'(TURNV); e.dc_b = 12'(TURNV);
    end else if (nst == ST_SL) begin
      e.dir_a = 2'b10; e.dir_b = 2'b01; e.dc_a = 12'(TURNV); e.dc_b = 12'(TURNV);
    end
    e.sd = m_d[0];
    e.ss = m_d[N-1];
    e.count = 8'(m_count);
    e.stare = 3'(nst);
    exp_q.push_back(e);

    m_d_prev = m_d;
    m_d = d_new;
    m_state = nst;
    m_s2_hist.push_back(m_s1);
    void'(m_s2_hist.pop_front());
    m_s1 = senzori;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(negedge clk);
      if (tact_count === 1'b1) tact_seen++;
    end
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    senzori = v;
    tick(n);
  endtask

  // monitor: one popped expectation per clock
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dirA",  32'(directie_driverA),  32'(e.dir_a));
        chk("dirB",  32'(directie_driverB),  32'(e.dir_b));
        chk("dcA",   32'(factor_dc_driverA), 32'(e.dc_a));
        chk("dcB",   32'(factor_dc_driverB), 32'(e.dc_b));
        chk("sdr",   32'(semnal_dreapta),    32'(e.sd));
        chk("sst",   32'(semnal_stanga),     32'(e.ss));
        chk("stop",  32'(stop),              32'(e.stop));
        chk("tact",  32'(tact_count),        32'(e.tact));
        chk("count", 32'(count_ture),        32'(e.count));
        chk("stare", 32'(stare),             32'(e.stare));
      end
    end
  end

  initial begin
    int t0, len;
    rst_n = 1'b0;
    enable = 1'($urandom);
    circuit = 2'($urandom);
    senzori = 5'($urandom);
    for (int k = 0; k < 3; k++) begin
      senzori = 5'($urandom);
      tick(1);
    end
    chk("rst_stare", 32'(stare), 0);
    chk("rst_stop", 32'(stop), 1);
    chk("rst_count", 32'(count_ture), 0);
    chk("rst_dcA", 32'(factor_dc_driverA), 0);

    rst_n = 1'b1; enable = 1'b1; circuit = 2'b11;
    hold(5'b00100, 12);
    chk("follow_stare", 32'(stare), ST_FOLLOW);
    chk("follow_dcA", 32'(factor_dc_driverA), 'h999);
    chk("follow_dirB", 32'(directie_driverB), 2);

    // proportional steering lands exactly DEB+3 cycles after the change
    hold(5'b00110, 6);
    chk("steer_early_dcB", 32'(factor_dc_driverB), 'h999);
    tick(1);
    chk("steer_dcB", 32'(factor_dc_driverB), 'h799);
    chk("steer_dcA", 32'(factor_dc_driverA), 'h999);

    hold(5'b00100, 10);
    hold(5'b00010, 3);
    hold(5'b00100, 10);
    chk("glitch_dcB", 32'(factor_dc_driverB), 'h999);

    hold(5'b00010, 8);
    hold(5'b00000, 10);
    chk("searchR_stare", 32'(stare), ST_SR);
    chk("searchR_dirA", 32'(directie_driverA), 1);
    chk("searchR_dcB", 32'(factor_dc_driverB), 'h600);
    hold(5'b00100, 10);
    chk("refollow_stare", 32'(stare), ST_FOLLOW);

    hold(5'b01000, 8);
    hold(5'b00000, 10);
    chk("searchL_stare", 32'(stare), ST_SL);
    chk("searchL_dirB", 32'(directie_driverB), 1);
    hold(5'b00100, 10);

    hold(5'b00010, 8);
    hold(5'b00000, 35);
    chk("lost_stare", 32'(stare), ST_LOST);
    chk("lost_stop", 32'(stop), 1);
    chk("lost_dirA", 32'(directie_driverA), 0);
    hold(5'b00100, 10);

    circuit = 2'b00; tick(2);
    circuit = 2'b01; hold(5'b00100, 10);
    t0 = tact_seen;
    for (int k = 0; k < 2; k++) begin
      hold(5'b11011, 8);
      hold(5'b00100, 8);
    end
    chk("c1_pulses", 32'(tact_seen - t0), 2);
    chk("c1_count", 32'(count_ture), 2);
    chk("c1_done", 32'(stare), ST_DONE);
    chk("c1_brake", 32'(directie_driverB), 0);

    circuit = 2'b00; tick(2);
    circuit = 2'b11; hold(5'b00100, 10);
    t0 = tact_seen;
    hold(5'b11011, 40);
    hold(5'b00100, 10);
    chk("long_mark_pulses", 32'(tact_seen - t0), 1);
    chk("long_mark_count", 32'(count_ture), 1);

    circuit = 2'b00; tick(3);
    chk("clear_count", 32'(count_ture), 0);
    chk("clear_stare", 32'(stare), ST_IDLE);

    circuit = 2'b10; hold(5'b00100, 10);
    for (int k = 0; k < 11; k++) begin
      hold(5'b11011, 6);
      hold(5'b00100, 6);
    end
    chk("c2_count", 32'(count_ture), 11);
    chk("c2_done", 32'(stare), ST_DONE);

    circuit = 2'b00; tick(2);
    circuit = 2'b11; hold(5'b00100, 10);
    for (int k = 0; k < 256; k++) begin
      hold(5'b11011, int'($urandom_range(5, 8)));
      hold(5'b00100, int'($urandom_range(5, 8)));
    end
    chk("sat_count", 32'(count_ture), 255);
    chk("sat_stare", 32'(stare), ST_FOLLOW);

    for (int k = 0; k < 300; k++) begin
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) circuit = 2'($urandom);
      len = int'($urandom_range(1, 10));
      hold(5'($urandom), len);
    end

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
